// File: rtl/input_check_seq.sv
// input_check_seq: checks player digits against the sequence just displayed.
// Optional no-input timeout enabled by defining INPUT_TIMEOUT_EN.
module input_check_seq #(
  parameter int TIMEOUT_TICKS = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        displayDone,
  input  logic [2:0]  curLvl,
  input  logic [19:0] seq,
  input  logic [3:0]  digitIn,
  input  logic        digitValid,
  input  logic        timer,
  output logic        inputActive,
  output logic [2:0]  digitIdx,
  output logic        pass,
  output logic        fail,
  output logic        enable_to_timer
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [19:0] seq_q, seq_d;
  logic [2:0]  lvl_q, lvl_d;
  logic [2:0]  idx_q, idx_d;
  logic        act_q, act_d;
  logic        pass_q, pass_d;
  logic        fail_q, fail_d;
  logic        en_q, en_d;
  logic [3:0]  nib;
  logic [2:0]  lvl_clamp;
  logic        last;

`ifdef INPUT_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
  logic [2:0] tick_q, tick_d;
  logic       tmo;
  assign tmo = timer && (tick_q == 3'(TIMEOUT_TICKS - 1));
`else
  localparam bit TMO_EN = 1'b0;
  logic unused_tmo;
  assign unused_tmo = timer & (TIMEOUT_TICKS > 0);
`endif

  always_comb begin
    case (idx_q)
      3'd0:    nib = seq_q[19:16];
      3'd1:    nib = seq_q[15:12];
      3'd2:    nib = seq_q[11:8];
      3'd3:    nib = seq_q[7:4];
      default: nib = seq_q[3:0];
    endcase
  end

  // Level 0 still checks one digit; 6 and 7 saturate at five.
  always_comb begin
    case (curLvl)
      3'd0:       lvl_clamp = 3'd1;
      3'd6, 3'd7: lvl_clamp = 3'd5;
      default:    lvl_clamp = curLvl;
    endcase
  end

  assign last = ((idx_q + 3'd1) == lvl_q);

  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    lvl_d   = lvl_q;
    idx_d   = idx_q;
    act_d   = act_q;
    pass_d  = 1'b0;
    fail_d  = 1'b0;
    en_d    = en_q;
`ifdef INPUT_TIMEOUT_EN
    tick_d  = tick_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (displayDone) begin
          seq_d   = seq;
          lvl_d   = lvl_clamp;
          idx_d   = 3'd0;
          act_d   = 1'b1;
          en_d    = TMO_EN;
          state_d = COLLECT;
`ifdef INPUT_TIMEOUT_EN
          tick_d  = 3'd0;
`endif
        end
      end
      COLLECT: begin
        if (digitValid) begin
          if (digitIn != nib) begin
            fail_d  = 1'b1;
            act_d   = 1'b0;
            en_d    = 1'b0;
            state_d = DONE;
          end else if (last) begin
            pass_d  = 1'b1;
            act_d   = 1'b0;
            en_d    = 1'b0;
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 3'd1;
`ifdef INPUT_TIMEOUT_EN
            tick_d  = 3'd0;
`endif
          end
`ifdef INPUT_TIMEOUT_EN
        end else if (tmo) begin
          fail_d  = 1'b1;
          act_d   = 1'b0;
          en_d    = 1'b0;
          state_d = DONE;
        end else if (timer) begin
          tick_d  = tick_q + 3'd1;
`endif
        end
      end
      DONE: begin
        idx_d   = 3'd0;
        act_d   = 1'b0;
        en_d    = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      seq_q   <= 20'h0;
      lvl_q   <= 3'd0;
      idx_q   <= 3'd0;
      act_q   <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      en_q    <= 1'b0;
`ifdef INPUT_TIMEOUT_EN
      tick_q  <= 3'd0;
`endif
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      lvl_q   <= lvl_d;
      idx_q   <= idx_d;
      act_q   <= act_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      en_q    <= en_d;
`ifdef INPUT_TIMEOUT_EN
      tick_q  <= tick_d;
`endif
    end
  end

  assign inputActive     = act_q;
  assign digitIdx        = idx_q;
  assign pass            = pass_q;
  assign fail            = fail_q;
  assign enable_to_timer = en_q;

endmodule

// File: tb/tb_input_check_seq.sv
// tb_input_check_seq: scenario tasks plus a pass/fail scoreboard.
// Timeout scenarios run when INPUT_TIMEOUT_EN is defined.
module tb_input_check_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        displayDone;
  logic [2:0]  curLvl;
  logic [19:0] seq;
  logic [3:0]  digitIn;
  logic        digitValid;
  logic        timer;
  logic        inputActive;
  logic [2:0]  digitIdx;
  logic        pass;
  logic        fail;
  logic        enable_to_timer;

  int n_checks = 0;
  int n_fail = 0;
  bit exp_q[$];
  bit sb_e;

  localparam logic [19:0] SEQ = 20'h3A5C1;

  always #5 clk = ~clk;

  input_check_seq #(.TIMEOUT_TICKS(5)) dut (
    .clk(clk), .rst(rst),
    .displayDone(displayDone), .curLvl(curLvl),
    .seq(seq), .digitIn(digitIn),
    .digitValid(digitValid), .timer(timer),
    .inputActive(inputActive), .digitIdx(digitIdx),
    .pass(pass), .fail(fail),
    .enable_to_timer(enable_to_timer)
  );

  // Result scoreboard: 1 = pass expected, 0 = fail expected.
  always @(negedge clk) begin
    if (pass || fail) begin
      n_checks++;
      if (pass && fail) begin
        n_fail++;
        $display("FAIL sb_onehot pass=%0b fail=%0b required one of them", pass, fail);
      end else if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected pass=%0b fail=%0b required no pulse", pass, fail);
      end else begin
        sb_e = exp_q.pop_front();
        if (pass !== sb_e) begin
          n_fail++;
          $display("FAIL sb_result pass=%0b required %0b", pass, sb_e);
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start(input logic [19:0] s, input logic [2:0] l);
    seq = s;
    curLvl = l;
    displayDone = 1'b1;
    step();
    displayDone = 1'b0;
  endtask

  // res: -1 no result expected, 1 pass, 0 fail.
  task automatic digit(input logic [3:0] d, input int res);
    if (res >= 0) exp_q.push_back(res[0]);
    digitIn = d;
    digitValid = 1'b1;
    step();
    digitValid = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      timer = 1'b1;
      step();
      timer = 1'b0;
      step();
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    step(2);
    rst = 1'b1;
    n_checks++; if (inputActive !== 1'b0) begin n_fail++; $display("FAIL rst_active got %0b required 0", inputActive); end
    n_checks++; if (digitIdx !== 3'd0) begin n_fail++; $display("FAIL rst_idx got %0d required 0", digitIdx); end
    n_checks++; if ({pass, fail} !== 2'b00) begin n_fail++; $display("FAIL rst_pf got %b required 00", {pass, fail}); end
    n_checks++; if (enable_to_timer !== 1'b0) begin n_fail++; $display("FAIL rst_en got %0b required 0", enable_to_timer); end
  endtask

  task automatic test_pass_lvl3;
    start(SEQ, 3'd3);
    n_checks++; if (inputActive !== 1'b1) begin n_fail++; $display("FAIL p3_active got %0b required 1", inputActive); end
    n_checks++; if (digitIdx !== 3'd0) begin n_fail++; $display("FAIL p3_idx0 got %0d required 0", digitIdx); end
    digit(4'h3, -1);
    n_checks++; if (digitIdx !== 3'd1) begin n_fail++; $display("FAIL p3_idx1 got %0d required 1", digitIdx); end
    digit(4'hA, -1);
    n_checks++; if (digitIdx !== 3'd2) begin n_fail++; $display("FAIL p3_idx2 got %0d required 2", digitIdx); end
    digit(4'h5, 1);
    n_checks++; if ({pass, fail} !== 2'b10) begin n_fail++; $display("FAIL p3_pulse got %b required 10", {pass, fail}); end
    n_checks++; if (inputActive !== 1'b0) begin n_fail++; $display("FAIL p3_inact got %0b required 0", inputActive); end
    step();
    n_checks++; if ({pass, fail} !== 2'b00) begin n_fail++; $display("FAIL p3_width got %b required 00", {pass, fail}); end
    n_checks++; if (digitIdx !== 3'd0) begin n_fail++; $display("FAIL p3_idxclr got %0d required 0", digitIdx); end
  endtask

  task automatic test_fail_lvl5;
    start(SEQ, 3'd5);
    digit(4'h3, -1);
    digit(4'hA, -1);
    digit(4'h7, 0);
    n_checks++; if ({pass, fail} !== 2'b01) begin n_fail++; $display("FAIL f5_pulse got %b required 01", {pass, fail}); end
    step();
    n_checks++; if ({pass, fail} !== 2'b00) begin n_fail++; $display("FAIL f5_width got %b required 00", {pass, fail}); end
    n_checks++; if (digitIdx !== 3'd0) begin n_fail++; $display("FAIL f5_idx got %0d required 0", digitIdx); end
  endtask

  task automatic test_clamp;
    start(SEQ, 3'd0);
    digit(4'h3, 1);
    n_checks++; if (pass !== 1'b1) begin n_fail++; $display("FAIL lvl0_pass got %0b required 1", pass); end
    step();
    start(SEQ, 3'd7);
    digit(4'h3, -1);
    digit(4'hA, -1);
    digit(4'h5, -1);
    digit(4'hC, -1);
    n_checks++; if (digitIdx !== 3'd4) begin n_fail++; $display("FAIL lvl7_idx4 got %0d required 4", digitIdx); end
    n_checks++; if (pass !== 1'b0) begin n_fail++; $display("FAIL lvl7_early got %0b required 0", pass); end
    digit(4'h1, 1);
    n_checks++; if (pass !== 1'b1) begin n_fail++; $display("FAIL lvl7_pass got %0b required 1", pass); end
    step();
  endtask

  task automatic test_reset_mid;
    start(SEQ, 3'd5);
    digit(4'h3, -1);
    digit(4'hA, -1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    n_checks++; if (inputActive !== 1'b0) begin n_fail++; $display("FAIL rm_active got %0b required 0", inputActive); end
    n_checks++; if (digitIdx !== 3'd0) begin n_fail++; $display("FAIL rm_idx got %0d required 0", digitIdx); end
    step(3);
    start(SEQ, 3'd1);
    n_checks++; if (inputActive !== 1'b1) begin n_fail++; $display("FAIL rm_restart got %0b required 1", inputActive); end
    digit(4'h3, 1);
    step();
  endtask

  task automatic test_done_window;
    start(SEQ, 3'd1);
    digit(4'h3, 1);
    displayDone = 1'b1;
    step();
    displayDone = 1'b0;
    n_checks++; if (inputActive !== 1'b0) begin n_fail++; $display("FAIL dw_lost got %0b required 0", inputActive); end
    digit(4'h3, -1);
    n_checks++; if ({inputActive, pass, fail} !== 3'b000) begin n_fail++; $display("FAIL dw_idle got %b required 000", {inputActive, pass, fail}); end
    step();
  endtask

  task automatic test_ignore_display;
    start(SEQ, 3'd3);
    digit(4'h3, -1);
    seq = 20'hFFFFF;
    curLvl = 3'd1;
    displayDone = 1'b1;
    step();
    displayDone = 1'b0;
    n_checks++; if (digitIdx !== 3'd1) begin n_fail++; $display("FAIL ig_idx got %0d required 1", digitIdx); end
    digit(4'hA, -1);
    n_checks++; if (inputActive !== 1'b1) begin n_fail++; $display("FAIL ig_active got %0b required 1", inputActive); end
    digit(4'h5, 1);
    n_checks++; if (pass !== 1'b1) begin n_fail++; $display("FAIL ig_pass got %0b required 1", pass); end
    step();
  endtask

`ifdef INPUT_TIMEOUT_EN
  task automatic test_timeout;
    start(SEQ, 3'd3);
    n_checks++; if (enable_to_timer !== 1'b1) begin n_fail++; $display("FAIL to_en got %0b required 1", enable_to_timer); end
    tick(4);
    n_checks++; if ({inputActive, fail} !== 2'b10) begin n_fail++; $display("FAIL to_early got %b required 10", {inputActive, fail}); end
    exp_q.push_back(1'b0);
    timer = 1'b1;
    step();
    timer = 1'b0;
    n_checks++; if (fail !== 1'b1) begin n_fail++; $display("FAIL to_fail got %0b required 1", fail); end
    n_checks++; if (enable_to_timer !== 1'b0) begin n_fail++; $display("FAIL to_endrop got %0b required 0", enable_to_timer); end
    step();
  endtask

  task automatic test_timeout_coincident;
    start(SEQ, 3'd3);
    tick(4);
    timer = 1'b1;
    digit(4'h3, -1);
    timer = 1'b0;
    n_checks++; if ({fail, digitIdx} !== 4'b0001) begin n_fail++; $display("FAIL tc_digit got fail=%0b idx=%0d required 0/1", fail, digitIdx); end
    tick(4);
    n_checks++; if (inputActive !== 1'b1) begin n_fail++; $display("FAIL tc_cleared got %0b required 1", inputActive); end
    exp_q.push_back(1'b0);
    timer = 1'b1;
    step();
    timer = 1'b0;
    n_checks++; if (fail !== 1'b1) begin n_fail++; $display("FAIL tc_fail got %0b required 1", fail); end
    step();
  endtask
`else
  task automatic test_no_timeout;
    start(SEQ, 3'd2);
    tick(12);
    n_checks++; if ({inputActive, enable_to_timer} !== 2'b10) begin n_fail++; $display("FAIL nt_wait got %b required 10", {inputActive, enable_to_timer}); end
    digit(4'h3, -1);
    digit(4'hA, 1);
    n_checks++; if (pass !== 1'b1) begin n_fail++; $display("FAIL nt_pass got %0b required 1", pass); end
    step();
  endtask
`endif

  initial begin
    rst = 1'b0;
    displayDone = 1'b0;
    curLvl = 3'd0;
    seq = 20'h0;
    digitIn = 4'h0;
    digitValid = 1'b0;
    timer = 1'b0;
    test_reset();
    test_pass_lvl3();
    test_fail_lvl5();
    test_clamp();
    test_reset_mid();
    test_done_window();
    test_ignore_display();
`ifdef INPUT_TIMEOUT_EN
    test_timeout();
    test_timeout_coincident();
`else
    test_no_timeout();
`endif
    step(2);
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL sb_missing got %0d pending required 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
